// File: rtl/otter_mem_arbiter.sv
// Port-2 data-memory arbiter: MEM stage (R0) vs. secondary master (R1).
// Optional build macro: OTTER_ARB_ROUND_ROBIN_EN (round-robin contention).
module otter_mem_arbiter #(
  parameter int LOCK_MAX   = 16,
  parameter int LOCK_CNT_W = 5
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        R0_REQ,
  input  logic        R0_WE,
  input  logic [31:0] R0_ADDR,
  input  logic [31:0] R0_WDATA,
  input  logic [1:0]  R0_SIZE,
  input  logic        R0_SIGN,
  input  logic        R1_REQ,
  input  logic        R1_WE,
  input  logic [31:0] R1_ADDR,
  input  logic [31:0] R1_WDATA,
  input  logic [1:0]  R1_SIZE,
  input  logic        R1_SIGN,
  input  logic        R1_LOCK,
  output logic        R0_GNT,
  output logic        R1_GNT,
  output logic        R0_RVALID,
  output logic        R1_RVALID,
  output logic [31:0] R0_RDATA,
  output logic [31:0] R1_RDATA,
  output logic        RESP_ERR,
  output logic        ERR_STICKY,
  output logic        MEM_READ2,
  output logic        MEM_WRITE2,
  output logic [31:0] MEM_ADDR2,
  output logic [31:0] MEM_DIN2,
  output logic [1:0]  MEM_SIZE,
  output logic        MEM_SIGN,
  input  logic [31:0] MEM_DOUT2,
  input  logic        MEM_ERR
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] RD_RESP = 1'b1;
  localparam logic [LOCK_CNT_W-1:0] CNT_MAX = LOCK_CNT_W'(LOCK_MAX);

  logic [0:0]            state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  err_q, err_d;
  logic                  sticky_q, sticky_d;
  logic                  lock_q, lock_d;
  logic [LOCK_CNT_W-1:0] cnt_q, cnt_d;

  logic req0, req1, lock_win, forced;
  logic g0, g1;

  // Requests are masked while reset is held so nothing reaches memory.
  assign req0     = R0_REQ & RST_N;
  assign req1     = R1_REQ & RST_N;
  assign lock_win = lock_q & R1_LOCK & req1 & (cnt_q < CNT_MAX);
  assign forced   = (cnt_q == CNT_MAX) & req0;

`ifdef OTTER_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  // Remember the most recent winner (1 = R1).
  always_comb begin
    last_d = last_q;
    if (g1) last_d = 1'b1;
    else if (g0) last_d = 1'b0;
  end

  // last_q resets to R1 so R0 wins the first contention.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) last_q <= 1'b1;
    else        last_q <= last_d;
  end
`endif

  // Grant selection: lock, forced R0 slot, then single/contention.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (lock_win) begin
      g1 = 1'b1;
    end else if (forced) begin
      g0 = 1'b1;
    end else begin
      unique case (1'b1)
        req0 && !req1: g0 = 1'b1;
        req1 && !req0: g1 = 1'b1;
        req0 && req1: begin
`ifdef OTTER_ARB_ROUND_ROBIN_EN
          g0 = last_q;
          g1 = !last_q;
`else
          g0 = 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  assign R0_GNT = g0;
  assign R1_GNT = g1;

  // Memory port-2 command mirrors the winner; zero when idle.
  always_comb begin
    MEM_READ2  = 1'b0;
    MEM_WRITE2 = 1'b0;
    MEM_ADDR2  = '0;
    MEM_DIN2   = '0;
    MEM_SIZE   = '0;
    MEM_SIGN   = 1'b0;
    if (g0) begin
      MEM_READ2  = !R0_WE;
      MEM_WRITE2 = R0_WE;
      MEM_ADDR2  = R0_ADDR;
      MEM_DIN2   = R0_WDATA;
      MEM_SIZE   = R0_SIZE;
      MEM_SIGN   = R0_SIGN;
    end else if (g1) begin
      MEM_READ2  = !R1_WE;
      MEM_WRITE2 = R1_WE;
      MEM_ADDR2  = R1_ADDR;
      MEM_DIN2   = R1_WDATA;
      MEM_SIZE   = R1_SIZE;
      MEM_SIGN   = R1_SIGN;
    end
  end

  // Read tracking, error capture and lock bookkeeping.
  always_comb begin
    state_d  = IDLE;
    owner_d  = owner_q;
    err_d    = err_q;
    if (MEM_READ2) begin
      state_d = RD_RESP;
      owner_d = g1;
      err_d   = MEM_ERR;
    end
    sticky_d = sticky_q | (MEM_ERR & (g0 | g1));
    lock_d   = lock_q;
    cnt_d    = cnt_q;
    if (!R1_REQ || !R1_LOCK) begin
      lock_d = 1'b0;
      cnt_d  = '0;
    end else begin
      if (g1) lock_d = 1'b1;
      if (g0) cnt_d = '0;
      else if (g1 && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers; reset discards any outstanding read.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      lock_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
      lock_q   <= lock_d;
      cnt_q    <= cnt_d;
    end
  end

  assign R0_RVALID  = (state_q == RD_RESP) & !owner_q;
  assign R1_RVALID  = (state_q == RD_RESP) & owner_q;
  assign R0_RDATA   = R0_RVALID ? MEM_DOUT2 : '0;
  assign R1_RDATA   = R1_RVALID ? MEM_DOUT2 : '0;
  assign RESP_ERR   = (state_q == RD_RESP) & err_q;
  assign ERR_STICKY = sticky_q;

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Scoreboard bench for otter_mem_arbiter.
// Directed vectors; read responses checked by a decoupled monitor.
module tb_otter_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        R0_REQ, R0_WE, R0_SIGN;
  logic [31:0] R0_ADDR, R0_WDATA;
  logic [1:0]  R0_SIZE;
  logic        R1_REQ, R1_WE, R1_SIGN, R1_LOCK;
  logic [31:0] R1_ADDR, R1_WDATA;
  logic [1:0]  R1_SIZE;
  logic        R0_GNT, R1_GNT, R0_RVALID, R1_RVALID;
  logic [31:0] R0_RDATA, R1_RDATA;
  logic        RESP_ERR, ERR_STICKY;
  logic        MEM_READ2, MEM_WRITE2, MEM_SIGN;
  logic [31:0] MEM_ADDR2, MEM_DIN2;
  logic [1:0]  MEM_SIZE;
  logic [31:0] MEM_DOUT2 = 32'd0;
  logic        MEM_ERR;

`ifdef OTTER_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  otter_mem_arbiter dut (
    .CLK(CLK), .RST_N(RST_N),
    .R0_REQ(R0_REQ), .R0_WE(R0_WE), .R0_ADDR(R0_ADDR),
    .R0_WDATA(R0_WDATA), .R0_SIZE(R0_SIZE), .R0_SIGN(R0_SIGN),
    .R1_REQ(R1_REQ), .R1_WE(R1_WE), .R1_ADDR(R1_ADDR),
    .R1_WDATA(R1_WDATA), .R1_SIZE(R1_SIZE), .R1_SIGN(R1_SIGN),
    .R1_LOCK(R1_LOCK),
    .R0_GNT(R0_GNT), .R1_GNT(R1_GNT),
    .R0_RVALID(R0_RVALID), .R1_RVALID(R1_RVALID),
    .R0_RDATA(R0_RDATA), .R1_RDATA(R1_RDATA),
    .RESP_ERR(RESP_ERR), .ERR_STICKY(ERR_STICKY),
    .MEM_READ2(MEM_READ2), .MEM_WRITE2(MEM_WRITE2),
    .MEM_ADDR2(MEM_ADDR2), .MEM_DIN2(MEM_DIN2),
    .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN),
    .MEM_DOUT2(MEM_DOUT2), .MEM_ERR(MEM_ERR)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Memory model: registered read data, misalignment flags an error.
  logic [31:0] mem [0:1023];
  logic        mis;
  always_comb begin
    mis = 1'b0;
    case (MEM_SIZE)
      2'd1:    mis = MEM_ADDR2[0];
      2'd2:    mis = |MEM_ADDR2[1:0];
      default: mis = 1'b0;
    endcase
    MEM_ERR = (MEM_READ2 | MEM_WRITE2) & mis;
  end
  always @(posedge CLK) begin
    if (MEM_READ2)  MEM_DOUT2 <= mem[MEM_ADDR2[11:2]];
    if (MEM_WRITE2) mem[MEM_ADDR2[11:2]] <= MEM_DIN2;
  end

  typedef struct {
    int          cyc;
    bit          owner;
    logic [31:0] data;
    bit          err;
  } rsp_t;
  rsp_t q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic push(input bit o, input logic [31:0] d, input bit e);
    rsp_t r;
    r.cyc = cyc + 1;
    r.owner = o;
    r.data = d;
    r.err = e;
    q.push_back(r);
  endtask

  // Monitor: every cycle, compare response outputs against the queue head.
  always @(negedge CLK) begin
    rsp_t e;
    bit   hit;
    hit = 1'b0;
    e.cyc = 0; e.owner = 1'b0; e.data = 32'd0; e.err = 1'b0;
    if (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      hit = 1'b1;
      chk("rsp_cycle", e.cyc, cyc);
    end
    if (hit) begin
      chk("r0_rvalid", 32'(R0_RVALID), 32'(!e.owner));
      chk("r1_rvalid", 32'(R1_RVALID), 32'(e.owner));
      chk("r0_rdata", R0_RDATA, e.owner ? 32'd0 : e.data);
      chk("r1_rdata", R1_RDATA, e.owner ? e.data : 32'd0);
      chk("resp_err", 32'(RESP_ERR), 32'(e.err));
    end else begin
      chk("r0_rvalid_idle", 32'(R0_RVALID), 32'd0);
      chk("r1_rvalid_idle", 32'(R1_RVALID), 32'd0);
      chk("r0_rdata_idle", R0_RDATA, 32'd0);
      chk("r1_rdata_idle", R1_RDATA, 32'd0);
      chk("resp_err_idle", 32'(RESP_ERR), 32'd0);
    end
  end

  task automatic adv();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic r0(input bit rq, input bit we, input logic [31:0] a,
                    input logic [31:0] d);
    R0_REQ = rq; R0_WE = we; R0_ADDR = a; R0_WDATA = d;
    R0_SIZE = 2'd2; R0_SIGN = 1'b0;
  endtask

  task automatic r1(input bit rq, input bit we, input logic [31:0] a,
                    input logic [31:0] d, input bit lk);
    R1_REQ = rq; R1_WE = we; R1_ADDR = a; R1_WDATA = d;
    R1_SIZE = 2'd2; R1_SIGN = 1'b0; R1_LOCK = lk;
  endtask

  task automatic clr();
    r0(1'b0, 1'b0, 32'd0, 32'd0);
    r1(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic gnt(input string nm, input bit e0, input bit e1);
    chk({nm, "_g0"}, 32'(R0_GNT), 32'(e0));
    chk({nm, "_g1"}, 32'(R1_GNT), 32'(e1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    bit e0, e1;
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    mem[10'h040] = 32'hDEAD_BEEF;
    mem[10'h080] = 32'h1234_5678;
    mem[10'h081] = 32'hCAFE_F00D;

    // Reset: a pending request must not leak through.
    clr();
    RST_N = 1'b0;
    r0(1'b1, 1'b0, 32'h100, 32'd0);
    repeat (2) adv();
    settle();
    gnt("rst", 1'b0, 1'b0);
    chk("rst_mem_read", 32'(MEM_READ2), 32'd0);
    chk("rst_mem_addr", MEM_ADDR2, 32'd0);
    chk("rst_sticky", 32'(ERR_STICKY), 32'd0);
    clr();
    adv();
    RST_N = 1'b1;
    adv();

    // Single R0 read.
    r0(1'b1, 1'b0, 32'h100, 32'd0);
    settle();
    gnt("single", 1'b1, 1'b0);
    chk("single_mem_read", 32'(MEM_READ2), 32'd1);
    chk("single_mem_addr", MEM_ADDR2, 32'h100);
    chk("single_mem_size", 32'(MEM_SIZE), 32'd2);
    push(1'b0, 32'hDEAD_BEEF, 1'b0);
    adv();
    clr();
    settle();
    gnt("idle", 1'b0, 1'b0);
    chk("idle_mem_read", 32'(MEM_READ2), 32'd0);
    chk("idle_mem_addr", MEM_ADDR2, 32'd0);
    adv();

    // Back-to-back reads: R1 then R0.
    r1(1'b1, 1'b0, 32'h200, 32'd0, 1'b0);
    settle();
    gnt("b2b_a", 1'b0, 1'b1);
    push(1'b1, 32'h1234_5678, 1'b0);
    adv();
    clr();
    r0(1'b1, 1'b0, 32'h204, 32'd0);
    settle();
    gnt("b2b_b", 1'b1, 1'b0);
    push(1'b0, 32'hCAFE_F00D, 1'b0);
    adv();
    clr();
    adv();

    // R1 write (leaves last winner = R1).
    r1(1'b1, 1'b1, 32'h300, 32'hA5A5_0001, 1'b0);
    settle();
    gnt("wr", 1'b0, 1'b1);
    chk("wr_mem_write", 32'(MEM_WRITE2), 32'd1);
    chk("wr_mem_din", MEM_DIN2, 32'hA5A5_0001);
    adv();
    clr();
    adv();

    // Contention: both read for 4 cycles.
    r0(1'b1, 1'b0, 32'h100, 32'd0);
    r1(1'b1, 1'b0, 32'h200, 32'd0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      settle();
      e0 = RR ? (k % 2 == 0) : 1'b1;
      gnt("cont", e0, !e0);
      chk("cont_mem_addr", MEM_ADDR2, e0 ? 32'h100 : 32'h200);
      push(!e0, e0 ? 32'hDEAD_BEEF : 32'h1234_5678, 1'b0);
      adv();
    end
    clr();
    adv();

    // Read back the R1 write.
    r0(1'b1, 1'b0, 32'h300, 32'd0);
    settle();
    gnt("rdback", 1'b1, 1'b0);
    push(1'b0, 32'hA5A5_0001, 1'b0);
    adv();
    clr();
    adv();

    // Lock burst: 16 R1 grants, one forced R0, then R1 resumes.
    for (int k = 0; k < 22; k++) begin
      r1(k <= 20, 1'b1, 32'h400, 32'h0000_0400, 1'b1);
      r0(k >= 1, 1'b1, 32'h500, 32'h0000_0500);
      settle();
      e1 = (k <= 15) || (k >= 17 && k <= 20);
      e0 = (k == 16) || (k == 21);
      gnt("lock", e0, e1);
      chk("lock_mem_write", 32'(MEM_WRITE2), 32'd1);
      chk("lock_mem_addr", MEM_ADDR2, e0 ? 32'h500 : 32'h400);
      adv();
    end
    clr();
    adv();

    // Faulting read, then sticky error survives a clean read.
    settle();
    chk("sticky_pre", 32'(ERR_STICKY), 32'd0);
    adv();
    r0(1'b1, 1'b0, 32'h102, 32'd0);
    settle();
    gnt("err", 1'b1, 1'b0);
    push(1'b0, 32'hDEAD_BEEF, 1'b1);
    adv();
    clr();
    settle();
    chk("sticky_set", 32'(ERR_STICKY), 32'd1);
    repeat (3) adv();
    r0(1'b1, 1'b0, 32'h204, 32'd0);
    settle();
    push(1'b0, 32'hCAFE_F00D, 1'b0);
    adv();
    clr();
    settle();
    chk("sticky_hold", 32'(ERR_STICKY), 32'd1);
    adv();

    // Reset while a read is outstanding.
    r0(1'b1, 1'b0, 32'h100, 32'd0);
    settle();
    gnt("rstrd", 1'b1, 1'b0);
    adv();
    RST_N = 1'b0;
    settle();
    gnt("rstrd_low", 1'b0, 1'b0);
    chk("rstrd_mem_read", 32'(MEM_READ2), 32'd0);
    chk("rstrd_r0_rvalid", 32'(R0_RVALID), 32'd0);
    chk("rstrd_sticky", 32'(ERR_STICKY), 32'd0);
    adv();
    RST_N = 1'b1;
    r1(1'b1, 1'b0, 32'h200, 32'd0, 1'b0);
    settle();
    gnt("post_rst", 1'b1, 1'b0);
    push(1'b0, 32'hDEAD_BEEF, 1'b0);
    adv();
    r0(1'b0, 1'b0, 32'd0, 32'd0);
    settle();
    gnt("post_rst_r1", 1'b0, 1'b1);
    push(1'b1, 32'h1234_5678, 1'b0);
    adv();
    clr();
    repeat (2) adv();

    chk("sb_drain", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
